// File: rtl/posit_word_encoder.sv
// posit_word_encoder: packs a signed raw scale, result sign, NaR/zero flags and
// a normalised fraction into an N-bit posit with round-to-nearest-even,
// saturation to maxpos/minpos and two's-complement negation.
//
// state | meaning
// IDLE  | waiting for start; all inputs captured when start is seen
// SPLIT | split scale into regime k and exponent e; range-check k
// PACK  | lay out regime, exponent and fraction; derive guard and sticky
// ROUND | round, saturate, negate; register posit_out and sat_out
// DONE  | result presented (done raised here); ack returns to IDLE
module posit_word_encoder #(
  parameter int N        = 32,
  parameter int ES       = 3,
  parameter int K_BITS   = 6,
  parameter int MAX_BITS = ES + K_BITS,
  parameter int FRAC_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [MAX_BITS-1:0] scale_in,
  input  logic [FRAC_W-1:0]   frac_in,
  input  logic                sign_in,
  input  logic                nar_in,
  input  logic                zero_in,
  input  logic                ack,
  output logic [N-1:0]        posit_out,
  output logic                done,
  output logic                sat_out
);

  localparam int TAIL_W = ES + FRAC_W;
  localparam int SW     = N + TAIL_W;
  localparam logic signed [K_BITS-1:0] K_MAX = K_BITS'(N - 2);
  localparam logic signed [K_BITS-1:0] K_MIN = K_BITS'(-(N - 1));
  localparam logic [K_BITS:0] RUN_ONE  = (K_BITS + 1)'(1);
  localparam logic [K_BITS:0] BODY_LEN = (K_BITS + 1)'(N - 1);

  typedef enum logic [2:0] {IDLE, SPLIT, PACK, ROUND, DONE} state_t;

  state_t                     state;
  logic [MAX_BITS-1:0]        scale_r;
  logic [FRAC_W-1:0]          frac_r;
  logic                       sign_r, nar_r, zero_r;
  logic signed [K_BITS-1:0]   k_r;
  logic [ES-1:0]              e_r;
  logic                       over_r, under_r;
  logic [N-2:0]               body_r;
  logic                       guard_r, sticky_r;

  // Upper scale bits are exactly scale >>> ES.
  logic signed [K_BITS-1:0]   k_w;
  assign k_w = scale_r[MAX_BITS-1:ES];

  logic [K_BITS:0]            k_ext, run, shamt;
  logic [N-1:0]               regime;
  logic [SW-1:0]              stream;

  // Build one MSB-first stream: regime run + terminator, then e, then fraction.
  // A run that fills the body pushes its terminator into the guard position.
  always_comb begin
    k_ext = {k_r[K_BITS-1], k_r};
    if (k_r[K_BITS-1]) begin
      run    = -k_ext;
      regime = {1'b1, {(N-1){1'b0}}} >> run;
    end else begin
      run    = k_ext + RUN_ONE;
      regime = ~({N{1'b1}} >> run);
    end
    shamt  = BODY_LEN - run;
    stream = {regime, {TAIL_W{1'b0}}} | ({{N{1'b0}}, e_r, frac_r} << shamt);
  end

  logic [N-1:0] sum, mag, posit_next;
  logic         round_up, sat_next;

  // Round to nearest-even, clamp into [minpos, maxpos], apply sign and specials.
  always_comb begin
    round_up = guard_r & (body_r[0] | sticky_r);
    sum      = {1'b0, body_r} + {{(N-1){1'b0}}, round_up};
    mag      = sum;
    sat_next = 1'b0;
    if (over_r || sum[N-1]) begin
      mag      = {1'b0, {(N-1){1'b1}}};
      sat_next = 1'b1;
    end else if (under_r) begin
      mag      = {{(N-1){1'b0}}, 1'b1};
      sat_next = 1'b1;
    end else if (sum == '0) begin
      mag = {{(N-1){1'b0}}, 1'b1};
    end
    posit_next = sign_r ? -mag : mag;
    if (nar_r) begin
      posit_next = {1'b1, {(N-1){1'b0}}};
      sat_next   = 1'b0;
    end else if (zero_r) begin
      posit_next = '0;
      sat_next   = 1'b0;
    end
  end

  // Handshake FSM; every datapath stage is registered between states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      scale_r   <= '0;
      frac_r    <= '0;
      sign_r    <= 1'b0;
      nar_r     <= 1'b0;
      zero_r    <= 1'b0;
      k_r       <= '0;
      e_r       <= '0;
      over_r    <= 1'b0;
      under_r   <= 1'b0;
      body_r    <= '0;
      guard_r   <= 1'b0;
      sticky_r  <= 1'b0;
      posit_out <= '0;
      done      <= 1'b0;
      sat_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            scale_r <= scale_in;
            frac_r  <= frac_in;
            sign_r  <= sign_in;
            nar_r   <= nar_in;
            zero_r  <= zero_in;
            state   <= SPLIT;
          end
        end
        SPLIT: begin
          k_r     <= k_w;
          e_r     <= scale_r[ES-1:0];
          over_r  <= k_w > K_MAX;
          under_r <= k_w < K_MIN;
          state   <= PACK;
        end
        PACK: begin
          body_r   <= stream[SW-1 -: N-1];
          guard_r  <= stream[SW-N];
          sticky_r <= |stream[SW-N-1:0];
          state    <= ROUND;
        end
        ROUND: begin
          posit_out <= posit_next;
          sat_out   <= sat_next;
          state     <= DONE;
        end
        DONE: begin
          if (!done) begin
            done <= 1'b1;
          end else if (ack) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_posit_word_encoder.sv
// tb_posit_word_encoder: directed vectors for posit_word_encoder, checked every
// cycle against a bit-queue model of the posit encoding rules.
module tb_posit_word_encoder;

  localparam int N        = 32;
  localparam int ES       = 3;
  localparam int K_BITS   = 6;
  localparam int MAX_BITS = 9;
  localparam int FRAC_W   = 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [MAX_BITS-1:0] scale_in = '0;
  logic [FRAC_W-1:0]   frac_in = '0;
  logic                sign_in = 1'b0;
  logic                nar_in = 1'b0;
  logic                zero_in = 1'b0;
  logic                ack = 1'b0;
  logic [N-1:0]        posit_out;
  logic                done;
  logic                sat_out;

  always #5 clk = ~clk;

  posit_word_encoder #(
    .N(N), .ES(ES), .K_BITS(K_BITS), .MAX_BITS(MAX_BITS), .FRAC_W(FRAC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .scale_in(scale_in),
    .frac_in(frac_in), .sign_in(sign_in), .nar_in(nar_in), .zero_in(zero_in),
    .ack(ack), .posit_out(posit_out), .done(done), .sat_out(sat_out)
  );

  typedef struct {
    int          scale;
    logic [31:0] frac;
    bit          sign;
    bit          nar;
    bit          zero;
    logic [31:0] p;
    bit          s;
  } vec_t;

  vec_t vecs[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit armed = 1'b0;
  bit chk_idle = 1'b0;
  int start_cyc = 0;
  int ack_cyc = 0;
  int vec_id = 0;
  logic [N-1:0] exp_posit = '0, lit_posit = '0;
  bit exp_sat = 1'b0, lit_sat = 1'b0;

  // Posit encoding from first principles: regime/exponent/fraction bit queue.
  function automatic void model(input int scale, input logic [31:0] frac,
                                input bit sign, input bit nar, input bit zero,
                                output logic [31:0] p, output bit s);
    int     e, k;
    bit     q[$];
    longint body;
    bit     g, st;
    s = 1'b0;
    if (nar) begin p = 32'h8000_0000; return; end
    if (zero) begin p = 32'h0; return; end
    e = ((scale % 8) + 8) % 8;
    k = (scale - e) / 8;
    if (k > 30) begin
      body = 64'h7FFF_FFFF; s = 1'b1;
    end else if (k < -31) begin
      body = 1; s = 1'b1;
    end else begin
      if (k >= 0) begin
        for (int i = 0; i < k + 1; i++) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      for (int i = 2; i >= 0; i--) q.push_back(bit'((e >> i) & 1));
      for (int i = 31; i >= 0; i--) q.push_back(frac[i]);
      body = 0;
      for (int i = 0; i < 31; i++) body = body * 2 + longint'(q[i]);
      g  = q[31];
      st = 1'b0;
      for (int i = 32; i < q.size(); i++) st = st | q[i];
      if (g && ((body % 2) == 1 || st)) body = body + 1;
      if (body > 64'h7FFF_FFFF) begin body = 64'h7FFF_FFFF; s = 1'b1; end
      if (body == 0) body = 1;
    end
    p = 32'(body);
    if (sign) p = -p;
  endfunction

  // Compare process: every negedge, check idle/reset state or the active encode.
  initial begin
    int rel;
    bit want_done;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (chk_idle) begin
        checks++;
        if (posit_out !== '0 || done !== 1'b0 || sat_out !== 1'b0) begin
          errors++;
          $display("FAIL idle_state: got posit=%h done=%b sat=%b, want 00000000 0 0",
                   posit_out, done, sat_out);
        end
      end
      if (armed) begin
        rel = cyc - start_cyc;
        if (rel == 0) begin
          checks++;
          if (exp_posit !== lit_posit || exp_sat !== lit_sat) begin
            errors++;
            $display("FAIL model_vec%0d: model %h sat=%b, hand value %h sat=%b",
                     vec_id, exp_posit, exp_sat, lit_posit, lit_sat);
          end
        end
        want_done = (rel >= 4) && (cyc <= ack_cyc);
        checks++;
        if (done !== want_done) begin
          errors++;
          $display("FAIL done_vec%0d rel=%0d: got done=%b, want %b", vec_id, rel, done, want_done);
        end
        if (done === 1'b1 && want_done) begin
          checks++;
          if (posit_out !== exp_posit || sat_out !== exp_sat) begin
            errors++;
            $display("FAIL out_vec%0d rel=%0d: got %h sat=%b, want %h sat=%b",
                     vec_id, rel, posit_out, sat_out, exp_posit, exp_sat);
          end
        end
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic run_vec(input int i, input int hold, input bit poke);
    logic [31:0] mp;
    bit          ms;
    model(vecs[i].scale, vecs[i].frac, vecs[i].sign, vecs[i].nar, vecs[i].zero, mp, ms);
    vec_id    = i;
    exp_posit = mp;
    exp_sat   = ms;
    lit_posit = vecs[i].p;
    lit_sat   = vecs[i].s;
    scale_in  = MAX_BITS'(vecs[i].scale);
    frac_in   = vecs[i].frac;
    sign_in   = vecs[i].sign;
    nar_in    = vecs[i].nar;
    zero_in   = vecs[i].zero;
    start     = 1'b1;
    start_cyc = cyc + 1;
    ack_cyc   = 1 << 30;
    armed     = 1'b1;
    tick;
    start    = 1'b0;
    scale_in = ~scale_in;
    frac_in  = ~frac_in;
    sign_in  = ~sign_in;
    nar_in   = ~nar_in;
    zero_in  = ~zero_in;
    if (poke) begin
      tick;
      start = 1'b1;
      tick;
      start = 1'b0;
    end
    for (int w = 0; w < 12 && done !== 1'b1; w++) tick;
    for (int h = 0; h < hold; h++) begin
      start = poke && (h == 0);
      tick;
    end
    start   = 1'b0;
    ack     = 1'b1;
    ack_cyc = cyc;
    tick;
    ack   = 1'b0;
    armed = 1'b0;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    vecs.push_back('{0,    32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 1'b0});
    vecs.push_back('{1,    32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h4400_0000, 1'b0});
    vecs.push_back('{-8,   32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h2000_0000, 1'b0});
    vecs.push_back('{0,    32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'hC000_0000, 1'b0});
    vecs.push_back('{0,    32'h0000_0020, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 1'b0});
    vecs.push_back('{0,    32'h0000_0060, 1'b0, 1'b0, 1'b0, 32'h4000_0002, 1'b0});
    vecs.push_back('{247,  32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0});
    vecs.push_back('{255,  32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1});
    vecs.push_back('{-256, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 1'b1});
    vecs.push_back('{-256, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{5,    32'h1234_5678, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b0});
    vecs.push_back('{5,    32'h1234_5678, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0});
    vecs.push_back('{9,    32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h6200_0000, 1'b0});
    vecs.push_back('{0,    32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h4200_0000, 1'b0});
    vecs.push_back('{-247, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 1'b0});
    vecs.push_back('{-1,   32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h3C00_0000, 1'b0});
    vecs.push_back('{-1,   32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'hC400_0000, 1'b0});

    chk_idle = 1'b1;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    chk_idle = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      run_vec(i, (i == 0 || i == 7) ? 3 : 0, (i == 0 || i == 7));

    // Abort in ROUND: last result is nonzero, reset must clear it at once.
    scale_in = 9'd1;
    frac_in  = '0;
    sign_in  = 1'b0;
    nar_in   = 1'b0;
    zero_in  = 1'b0;
    start    = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    rst_n    = 1'b0;
    chk_idle = 1'b1;
    tick;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick;
    chk_idle = 1'b0;

    run_vec(1, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
